// File: rtl/jtag_scan_master.sv
// jtag_scan_master: drives TMS/TDI to walk a TAP through complete IR/DR scans
// and captures TDO, lock-step with the TAP on clk_i.
// Optional build macro: JTAG_MASTER_TDO_CAPTURE_EN keeps the TDO capture path.
// Without it, tdo_i is ignored and data_out_o is constant 0.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RST_SEQ | TMS=1 for 5 cycles (TAP -> Test-Logic-Reset), then TMS=0 once
// IDLE    | TMS=0, TAP parked in Run-Test/Idle, waiting for start/reset_tap
// SEL_DR  | TMS=1, TAP -> Select-DR-Scan
// SEL_IR  | TMS=1, TAP -> Select-IR-Scan (IR scans only)
// CAPTURE | TMS=0 for 2 cycles, TAP -> Capture -> Shift
// SHIFT   | one cycle per bit, TMS=1 on the last bit (Shift -> Exit1)
// EXIT1   | TMS=1, TAP -> Update
// UPDATE  | TMS=0, TAP -> Run-Test/Idle; done pulses in the next IDLE cycle

module jtag_scan_master #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              is_ir_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [DATA_W-1:0] data_in_i,
    input  logic              reset_tap_i,
    input  logic              tdo_i,
    output logic              tms_o,
    output logic              tdi_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] data_out_o
);

    // Counter must hold both len-1 and the reset-sequence count of 5.
    localparam int CNT_W = (LEN_W < 3) ? 3 : LEN_W;

    typedef enum logic [2:0] {
        RST_SEQ, IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              is_ir_q, is_ir_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              tms_q, tms_d;
    logic              tdi_q, tdi_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              accept;
    logic              shift_en;
    logic              last_bit;

    // Next-state, down-counter and scan-data sequencing; TMS/TDI are derived
    // from the next state so they leave the flops aligned with the state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_ir_d  = is_ir_q;
        len_d    = len_q;
        din_d    = din_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        accept   = 1'b0;
        shift_en = 1'b0;
        last_bit = 1'b0;
        tms_d    = 1'b0;
        tdi_d    = 1'b0;

        case (state_q)
            RST_SEQ: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            IDLE: begin
                // reset_tap has priority; a simultaneous start is dropped.
                if (reset_tap_i) begin
                    state_d = RST_SEQ;
                    cnt_d   = CNT_W'(5);
                    busy_d  = 1'b1;
                end else if (start_i) begin
                    accept  = 1'b1;
                    state_d = SEL_DR;
                    is_ir_d = is_ir_i;
                    len_d   = (len_i == '0) ? LEN_W'(1) : len_i;
                    din_d   = data_in_i;
                    busy_d  = 1'b1;
                end
            end
            SEL_DR: begin
                state_d = is_ir_q ? SEL_IR : CAPTURE;
                cnt_d   = CNT_W'(1);
            end
            SEL_IR: begin
                state_d = CAPTURE;
                cnt_d   = CNT_W'(1);
            end
            CAPTURE: begin
                if (cnt_q == '0) begin
                    state_d = SHIFT;
                    cnt_d   = CNT_W'(len_q) - CNT_W'(1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                din_d    = din_q >> 1;
                if (cnt_q == '0) begin
                    last_bit = 1'b1;
                    state_d  = EXIT1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            EXIT1: begin
                state_d = UPDATE;
            end
            UPDATE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = RST_SEQ;
                cnt_d   = CNT_W'(5);
                busy_d  = 1'b1;
            end
        endcase

        case (state_d)
            RST_SEQ:               tms_d = (cnt_d != '0);
            SEL_DR, SEL_IR, EXIT1: tms_d = 1'b1;
            SHIFT:                 tms_d = (cnt_d == '0);
            default:               tms_d = 1'b0;
        endcase

        if (state_d == SHIFT) begin
            tdi_d = din_d[0];
        end
    end

    // State and output registers; reset mirrors a reset_tap accept so the TAP
    // is always resynchronised.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RST_SEQ;
            cnt_q   <= CNT_W'(5);
            is_ir_q <= 1'b0;
            len_q   <= LEN_W'(1);
            din_q   <= '0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            is_ir_q <= is_ir_d;
            len_q   <= len_d;
            din_q   <= din_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tms_o  = tms_q;
    assign tdi_o  = tdi_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

`ifdef JTAG_MASTER_TDO_CAPTURE_EN
    logic [DATA_W-1:0] cap_q, cap_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [DATA_W-1:0] cap_shifted;

    // TDO enters at the MSB; on the last bit the result is right-justified.
    always_comb begin
        cap_d       = cap_q;
        dout_d      = dout_q;
        cap_shifted = {tdo_i, cap_q[DATA_W-1:1]};
        if (accept) begin
            cap_d  = '0;
            dout_d = '0;
        end else if (shift_en) begin
            cap_d = cap_shifted;
            if (last_bit) begin
                dout_d = cap_shifted >> (DATA_W - int'(len_q));
            end
        end
    end

    // Capture and result registers; reset discards any partial scan.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cap_q  <= '0;
            dout_q <= '0;
        end else begin
            cap_q  <= cap_d;
            dout_q <= dout_d;
        end
    end

    assign data_out_o = dout_q;
`else
    logic unused_capture_sigs;
    assign unused_capture_sigs = ^{tdo_i, accept, shift_en, last_bit};
    assign data_out_o = '0;
`endif

endmodule

// File: tb/tb_jtag_scan_master.sv
// Directed bench for jtag_scan_master with a 16-state TAP model attached.
module tb_jtag_scan_master;

    localparam int DATA_W = 32;
    localparam int LEN_W  = 6;

`ifdef JTAG_MASTER_TDO_CAPTURE_EN
    localparam bit CAP_EN = 1'b1;
`else
    localparam bit CAP_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              is_ir;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] data_in;
    logic              reset_tap;
    logic              tdo;
    logic              tms;
    logic              tdi;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] data_out;

    always #5 clk = ~clk;

    jtag_scan_master #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .is_ir_i     (is_ir),
        .len_i       (len),
        .data_in_i   (data_in),
        .reset_tap_i (reset_tap),
        .tdo_i       (tdo),
        .tms_o       (tms),
        .tdi_o       (tdi),
        .busy_o      (busy),
        .done_o      (done),
        .data_out_o  (data_out)
    );

    // ---------------- TAP model ----------------
    typedef enum logic [3:0] {
        TLR, RTI, SDR, CDR, SHDR, E1DR, PDR, E2DR, UDR,
        SIR, CIR, SHIR, E1IR, PIR, E2IR, UIR
    } tap_t;

    tap_t       tap    = SHDR;
    logic [3:0] ir_sh  = 4'h0;
    logic [3:0] ir_reg = 4'h0;

    function automatic tap_t tap_next(input tap_t s, input logic m);
        case (s)
            TLR:  return m ? TLR  : RTI;
            RTI:  return m ? SDR  : RTI;
            SDR:  return m ? SIR  : CDR;
            CDR:  return m ? E1DR : SHDR;
            SHDR: return m ? E1DR : SHDR;
            E1DR: return m ? UDR  : PDR;
            PDR:  return m ? E2DR : PDR;
            E2DR: return m ? UDR  : SHDR;
            UDR:  return m ? SDR  : RTI;
            SIR:  return m ? TLR  : CIR;
            CIR:  return m ? E1IR : SHIR;
            SHIR: return m ? E1IR : SHIR;
            E1IR: return m ? UIR  : PIR;
            PIR:  return m ? E2IR : PIR;
            E2IR: return m ? UIR  : SHIR;
            default: return m ? SDR : RTI;
        endcase
    endfunction

    always @(posedge clk) begin
        if (tap == CIR)       ir_sh <= 4'b0001;
        else if (tap == SHIR) ir_sh <= {tdi, ir_sh[3:1]};
        if (tap == UIR)       ir_reg <= ir_sh;
        tap <= tap_next(tap, tms);
    end

    // IR shifts out the TAP's IR register; everything else loops TDI back.
    assign tdo = (tap == SHIR) ? ir_sh[0] : tdi;

    // ---------------- checking ----------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic ir, input logic [LEN_W-1:0] l,
                         input logic [DATA_W-1:0] d, input logic st, input logic rt);
        is_ir     = ir;
        len       = l;
        data_in   = d;
        start     = st;
        reset_tap = rt;
        tick();
        start     = 1'b0;
        reset_tap = 1'b0;
    endtask

    // Records TMS/TDI per cycle until done (bounded); optional start+reset_tap
    // poke and optional rst pulse at a given cycle index.
    task automatic collect(input int poke_n, input int rst_at, output int n,
                           output logic [63:0] tms_s, output logic [63:0] tdi_s);
        n     = 0;
        tms_s = '0;
        tdi_s = '0;
        while (n < 60) begin
            tms_s[n] = tms;
            tdi_s[n] = tdi;
            if (n == poke_n) begin
                start     = 1'b1;
                reset_tap = 1'b1;
                is_ir     = 1'b1;
                len       = 6'd3;
                data_in   = 32'h5;
            end
            if (n == rst_at) rst = 1'b1;
            tick();
            start     = 1'b0;
            reset_tap = 1'b0;
            rst       = 1'b0;
            n++;
            if (done) break;
        end
    endtask

    typedef struct {
        logic              ir;
        logic [LEN_W-1:0]  len;
        logic [DATA_W-1:0] data;
        logic [63:0]       tms;
        int                cyc;
        logic [63:0]       tdi;
        logic [DATA_W-1:0] dout;
    } vec_t;

    vec_t        vecs[5];
    int          n;
    logic [63:0] tms_s, tdi_s;

    initial begin
        rst = 1'b1; start = 1'b0; is_ir = 1'b0; len = '0; data_in = '0; reset_tap = 1'b0;
        vecs[0] = '{1'b0, 6'd8,  32'hA5,       64'hC01,         13, 64'h528,         32'hA5};
        vecs[1] = '{1'b1, 6'd4,  32'h3,        64'h183,         10, 64'h30,          32'h1};
        vecs[2] = '{1'b0, 6'd1,  32'h1,        64'h19,           6, 64'h8,           32'h1};
        vecs[3] = '{1'b0, 6'd32, 32'hDEADBEEF, 64'hC_0000_0001, 37, 64'h6_F56D_F778, 32'hDEADBEEF};
        vecs[4] = '{1'b0, 6'd0,  32'hFFFFFFFF, 64'h19,           6, 64'h8,           32'h1};

        tick();
        tick();
        check("rst_tms",  64'(tms), 64'd1);
        check("rst_tdi",  64'(tdi), 64'd0);
        check("rst_busy", 64'(busy), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dout", 64'(data_out), 64'd0);

        rst = 1'b0;
        collect(-1, -1, n, tms_s, tdi_s);
        check("rel_cycles", 64'(n), 64'd6);
        check("rel_tms",    tms_s, 64'h1F);
        check("rel_tap",    64'(tap), 64'(RTI));
        check("rel_busy",   64'(busy), 64'd0);

        // Back-to-back scans, each started in the done cycle of the previous one.
        for (int i = 0; i < 5; i++) begin
            issue(vecs[i].ir, vecs[i].len, vecs[i].data, 1'b1, 1'b0);
            collect(-1, -1, n, tms_s, tdi_s);
            check($sformatf("v%0d_cycles", i), 64'(n), 64'(vecs[i].cyc));
            check($sformatf("v%0d_tms", i), tms_s, vecs[i].tms);
            check($sformatf("v%0d_tdi", i), tdi_s, vecs[i].tdi);
            check($sformatf("v%0d_dout", i), 64'(data_out), CAP_EN ? 64'(vecs[i].dout) : 64'd0);
            check($sformatf("v%0d_tap", i), 64'(tap), 64'(RTI));
            check($sformatf("v%0d_busy", i), 64'(busy), 64'd0);
            if (vecs[i].ir) check("ir_reg", 64'(ir_reg), 64'h3);
        end

        // start and reset_tap while busy are ignored.
        issue(1'b0, 6'd8, 32'hA5, 1'b1, 1'b0);
        collect(5, -1, n, tms_s, tdi_s);
        check("busy_cycles", 64'(n), 64'd13);
        check("busy_tms",    tms_s, 64'hC01);
        check("busy_tdi",    tdi_s, 64'h528);
        check("busy_dout",   64'(data_out), CAP_EN ? 64'hA5 : 64'd0);

        // start + reset_tap together in IDLE: only the reset sequence runs.
        issue(1'b0, 6'd8, 32'h5A, 1'b1, 1'b1);
        collect(-1, -1, n, tms_s, tdi_s);
        check("rtap_cycles", 64'(n), 64'd6);
        check("rtap_tms",    tms_s, 64'h1F);
        check("rtap_tdi",    tdi_s, 64'd0);
        check("rtap_tap",    64'(tap), 64'(RTI));

        // rst during SHIFT bit 3 of an 8-bit scan.
        issue(1'b0, 6'd8, 32'hA5, 1'b1, 1'b0);
        collect(-1, 6, n, tms_s, tdi_s);
        check("abort_cycles", 64'(n), 64'd13);
        check("abort_tms",    tms_s, 64'hF81);
        check("abort_tdi",    tdi_s, 64'h28);
        check("abort_dout",   64'(data_out), 64'd0);
        check("abort_tap",    64'(tap), 64'(RTI));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
